kara_pp_gen_64bit: RTL and testbench
====================================

// Module: kara_pp_gen_64bit
// PURPOSE
//  Iterative 64x64 carry-less (GF(2)[x]) Karatsuba partial-product generator.
//  Splits a,b into 32-bit halves; produces z0=a_lo*b_lo, z2=a_hi*b_hi, z1=(a_lo^a_hi)*(b_lo^b_hi), each 63 bits.
//  Sits directly upstream of the 64-bit output-recombination stage, which XOR-folds z0/z1/z2 into y.
//  Valid/ready on both sides; one operation in flight.
// PARAMETERS
//  HALF_W  32  half-operand width; product width is 2*HALF_W-1 = 63
//  DIGIT   4   multiplier bits consumed per cycle per product; must divide HALF_W (1,2,4,8,16,32)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   operand pair a,b valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  a          in   64  operand A
//  b          in   64  operand B
//  out_valid  out  1   z0/z1/z2 valid and stable
//  out_ready  in   1   downstream consumes result
//  z0         out  63  a_lo*b_lo (carry-less)
//  z1         out  63  (a_lo^a_hi)*(b_lo^b_hi) (raw middle product, not corrected)
//  z2         out  63  a_hi*b_hi
//  pp_par     out  3   {^z2,^z1,^z0}; only with KARA_PP_PARITY_EN
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, z0=z1=z2=0, counter=0, pp_par=0.
//  FSM IDLE -> CALC on in_valid&in_ready: latch a_lo,a_hi,a_mid=a_lo^a_hi and b_lo,b_hi,b_mid;
//   clear three 63-bit accumulators; cnt=0.
//  CALC: per cycle, for j in 0..DIGIT-1, k=cnt*DIGIT+j: acc_x ^= b_x[k] ? (a_x<<k) : 0 (x in lo,mid,hi);
//   shifts zero-extend to 63 bits, no bit lost. cnt++; when cnt==HALF_W/DIGIT-1 -> DONE.
//  DONE: out_valid=1, z* = accumulators, held stable until out_valid&out_ready; then -> IDLE next cycle.
//  Latency: in handshake to out_valid = HALF_W/DIGIT + 1 cycles (9 at defaults).
//  in_ready is 0 in CALC and DONE; in_valid there is ignored (no buffering, no drop flag).
//  out_ready while out_valid=0 has no effect. out_ready held low -> DONE indefinitely, outputs frozen.
//  No same-cycle DONE->accept: new operand accepted earliest the cycle after result handshake.
//  z0/z1/z2 drive only from registers (no combinational path from a/b/out_ready to z*).
//  rst mid-CALC or in DONE: abort, return to reset values next edge; result discarded.
//  Zero operands take the full latency (no early exit), giving constant timing.
// CONFIGURATION
//  `KARA_PP_PARITY_EN defined: pp_par registered alongside z* at DONE entry, valid with out_valid;
//   reset 0. Undefined: pp_par port absent, no parity logic.
// STRUCTURE
//  Package kara_pkg: HALF_W, PROD_W=2*HALF_W-1, typedef logic [PROD_W-1:0] prod_t,
//   typedef enum {IDLE,CALC,DONE} kara_state_e. Shared by this block and the recombination stage.
//  One sub-module kara_digit_step: combinational acc_next = acc ^ sum_j(b_digit[j] ? a<<(base+j) : 0);
//   instantiated three times (lo, mid, hi). FSM, counter and handshake live in the top.
// TESTING
//  a=64'h1, b=64'h1 -> after 9 cycles z0=63'h1, z1=63'h1, z2=0; pp_par=3'b011.
//  a=b=64'hFFFF_FFFF_FFFF_FFFF -> z0=z2=63'h5555_5555_5555_5555, z1=0 (mid operands zero).
//  a=64'h8000_0000_0000_0000, b=64'h0000_0001_0000_0000 -> z2=63'h8000_0000, z0=0, z1=63'h8000_0000.
//  out_ready held low 20 cycles after out_valid -> z* stable, in_ready=0, new in_valid ignored.
//  rst pulsed at cycle 4 of CALC -> next cycle in_ready=1, out_valid=0, z*=0; next op correct.
//  1000 random a,b, random out_ready stalls, DIGIT in {1,4,32} -> z* match software clmul model.

Source files
------------

// File: rtl/kara_pkg.sv
// Shared types for the Karatsuba carry-less multiplier path
// (partial-product generator and the downstream recombination stage).
package kara_pkg;

  localparam int unsigned HALF_W = 32;
  localparam int unsigned PROD_W = 2 * HALF_W - 1;

  typedef logic [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } kara_state_e;

endpackage

// File: rtl/kara_pp_gen_64bit_if.sv
// Operand/result handshake bundle for kara_pp_gen_64bit.
// master = operand source and result sink, slave = the generator.
// pp_par exists only when KARA_PP_PARITY_EN is defined.
interface kara_pp_gen_64bit_if;
  import kara_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [2*HALF_W-1:0]   a;
  logic [2*HALF_W-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  prod_t                 z0;
  prod_t                 z1;
  prod_t                 z2;
`ifdef KARA_PP_PARITY_EN
  logic [2:0]            pp_par;
`endif

  modport master (
    output in_valid, a, b, out_ready,
`ifdef KARA_PP_PARITY_EN
    input  pp_par,
`endif
    input  in_ready, out_valid, z0, z1, z2
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef KARA_PP_PARITY_EN
    output pp_par,
`endif
    output in_ready, out_valid, z0, z1, z2
  );

endinterface

// File: rtl/kara_digit_step.sv
// One iteration of a digit-serial carry-less multiply:
// acc_next = acc ^ XOR_j (b_digit[j] ? a << (step*DIGIT + j) : 0).
module kara_digit_step #(
  parameter int unsigned HALF_W = 32,
  parameter int unsigned DIGIT  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic [HALF_W-1:0]   a,
  input  logic [DIGIT-1:0]    b_digit,
  input  logic [CNT_W-1:0]    step,
  input  logic [2*HALF_W-2:0] acc,
  output logic [2*HALF_W-2:0] acc_next
);

  logic [2*HALF_W-2:0] a_ext;

  assign a_ext = {{(HALF_W-1){1'b0}}, a};

  // XOR in the shifted multiplicand for every set bit of this multiplier digit
  always_comb begin
    acc_next = acc;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      if (b_digit[j]) begin
        acc_next = acc_next ^ (a_ext << (32'(step) * DIGIT + j));
      end
    end
  end

endmodule

// File: rtl/kara_pp_gen_64bit.sv
// Iterative 64x64 carry-less Karatsuba partial-product generator.
// Produces z0 = a_lo*b_lo, z1 = (a_lo^a_hi)*(b_lo^b_hi), z2 = a_hi*b_hi,
// DIGIT multiplier bits per cycle, fixed latency, one operation in flight.
// Optional feature macro: KARA_PP_PARITY_EN (adds registered pp_par).
module kara_pp_gen_64bit import kara_pkg::*; #(
  parameter int unsigned HALF_W = kara_pkg::HALF_W,
  parameter int unsigned DIGIT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  kara_pp_gen_64bit_if.slave bus
);

  localparam int unsigned NSTEP = HALF_W / DIGIT;
  localparam int unsigned CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

  kara_state_e state, state_next;

  logic              in_ready;
  logic              out_valid;
  logic              last;
  logic [CNT_W-1:0]  cnt;

  logic [HALF_W-1:0] a_lo, a_hi, a_mid;
  logic [HALF_W-1:0] b_lo, b_hi, b_mid;
  prod_t             acc_lo, acc_hi, acc_mid;
  prod_t             acc_lo_next, acc_hi_next, acc_mid_next;

  assign last = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, digit-serial accumulation and step counter.
  // Multiplier halves shift right so the active digit is always the low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_lo    <= '0;
      a_hi    <= '0;
      a_mid   <= '0;
      b_lo    <= '0;
      b_hi    <= '0;
      b_mid   <= '0;
      acc_lo  <= '0;
      acc_hi  <= '0;
      acc_mid <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_lo    <= bus.a[HALF_W-1:0];
            a_hi    <= bus.a[2*HALF_W-1:HALF_W];
            a_mid   <= bus.a[HALF_W-1:0] ^ bus.a[2*HALF_W-1:HALF_W];
            b_lo    <= bus.b[HALF_W-1:0];
            b_hi    <= bus.b[2*HALF_W-1:HALF_W];
            b_mid   <= bus.b[HALF_W-1:0] ^ bus.b[2*HALF_W-1:HALF_W];
            acc_lo  <= '0;
            acc_hi  <= '0;
            acc_mid <= '0;
            cnt     <= '0;
          end
        end
        CALC: begin
          acc_lo  <= acc_lo_next;
          acc_hi  <= acc_hi_next;
          acc_mid <= acc_mid_next;
          b_lo    <= b_lo >> DIGIT;
          b_hi    <= b_hi >> DIGIT;
          b_mid   <= b_mid >> DIGIT;
          cnt     <= last ? '0 : cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  kara_digit_step #(.HALF_W(HALF_W), .DIGIT(DIGIT), .CNT_W(CNT_W)) u_step_lo (
    .a        (a_lo),
    .b_digit  (b_lo[DIGIT-1:0]),
    .step     (cnt),
    .acc      (acc_lo),
    .acc_next (acc_lo_next)
  );

  kara_digit_step #(.HALF_W(HALF_W), .DIGIT(DIGIT), .CNT_W(CNT_W)) u_step_mid (
    .a        (a_mid),
    .b_digit  (b_mid[DIGIT-1:0]),
    .step     (cnt),
    .acc      (acc_mid),
    .acc_next (acc_mid_next)
  );

  kara_digit_step #(.HALF_W(HALF_W), .DIGIT(DIGIT), .CNT_W(CNT_W)) u_step_hi (
    .a        (a_hi),
    .b_digit  (b_hi[DIGIT-1:0]),
    .step     (cnt),
    .acc      (acc_hi),
    .acc_next (acc_hi_next)
  );

`ifdef KARA_PP_PARITY_EN
  // Parity captured from the final accumulator values on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pp_par <= '0;
    end else if (state == CALC && last) begin
      bus.pp_par <= {^acc_hi_next, ^acc_mid_next, ^acc_lo_next};
    end
  end
`endif

  // Accumulators are the result registers; they only change outside DONE
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.z0        = acc_lo;
  assign bus.z1        = acc_mid;
  assign bus.z2        = acc_hi;

endmodule

// File: tb/tb_kara_pp_gen_64bit.sv
// Directed-vector bench for kara_pp_gen_64bit (DIGIT = 4): hand-computed
// table, output-stall hold, reset abort, and model-checked random operands.
module tb_kara_pp_gen_64bit;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [62:0] z0;
    logic [62:0] z1;
    logic [62:0] z2;
  } vec_t;

  localparam int NVEC = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs [NVEC];

  kara_pp_gen_64bit_if bus ();

  kara_pp_gen_64bit #(.DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Carry-less product as a convolution: r[k] = XOR_i x[i] & y[k-i]
  function automatic logic [62:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [62:0] r;
    r = '0;
    for (int k = 0; k < 63; k++) begin
      for (int i = 0; i < 32; i++) begin
        if (k - i >= 0 && k - i < 32) r[k] = r[k] ^ (x[i] & y[k-i]);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One full operation; during a stall a junk operand is offered and must be ignored
  task automatic run_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [62:0] z0e, input logic [62:0] z1e,
                           input logic [62:0] z2e, input int stall, input bit ready_early);
    int lat;
    int held_bad;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = ready_early;
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd9);
    chk({tag, "_z0"}, 64'(bus.z0), 64'(z0e));
    chk({tag, "_z1"}, 64'(bus.z1), 64'(z1e));
    chk({tag, "_z2"}, 64'(bus.z2), 64'(z2e));
`ifdef KARA_PP_PARITY_EN
    chk({tag, "_pp_par"}, 64'(bus.pp_par), 64'({^z2e, ^z1e, ^z0e}));
`endif
    if (stall > 0) begin
      held_bad = 0;
      bus.a        = ~a;
      bus.b        = ~b;
      bus.in_valid = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (bus.z0 !== z0e || bus.z1 !== z1e || bus.z2 !== z2e ||
            bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) held_bad++;
      end
      chk({tag, "_hold_bad_cycles"}, 64'(held_bad), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int          st;

    vecs[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001,
                63'h1, 63'h1, 63'h0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                63'h5555_5555_5555_5555, 63'h0, 63'h5555_5555_5555_5555};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000,
                63'h0, 63'h8000_0000, 63'h8000_0000};
    vecs[3] = '{64'h0, 64'h0, 63'h0, 63'h0, 63'h0};
    vecs[4] = '{64'h0000_0003_0000_0003, 64'h0000_0003_0000_0003,
                63'h5, 63'h0, 63'h5};
    vecs[5] = '{64'h0000_0002_0000_0001, 64'h0000_0001_0000_0001,
                63'h1, 63'h0, 63'h2};
    vecs[6] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                63'h4000_0000_0000_0000, 63'h4000_0000_0000_0000, 63'h0};
    vecs[7] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF,
                63'h0, 63'h5555_5555_5555_5555, 63'h0};
    vecs[8] = '{64'h0000_0005_0000_0000, 64'h0000_0003_0000_0000,
                63'h0, 63'hF, 63'hF};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_z0", 64'(bus.z0), 64'd0);
    chk("reset_z1", 64'(bus.z1), 64'd0);
    chk("reset_z2", 64'(bus.z2), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                vecs[i].z0, vecs[i].z1, vecs[i].z2, 0, 1'b0);
    end

    // Downstream stalled 20 cycles with a competing operand offered
    run_check("stall20", vecs[1].a, vecs[1].b, vecs[1].z0, vecs[1].z1, vecs[1].z2, 20, 1'b0);
    // out_ready already high before out_valid
    run_check("ready_early", vecs[5].a, vecs[5].b, vecs[5].z0, vecs[5].z1, vecs[5].z2, 0, 1'b1);

    // Reset in the fourth CALC cycle aborts the operation
    bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.b        = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_z0", 64'(bus.z0), 64'd0);
    chk("abort_z1", 64'(bus.z1), 64'd0);
    chk("abort_z2", 64'(bus.z2), 64'd0);
    run_check("after_abort", vecs[2].a, vecs[2].b, vecs[2].z0, vecs[2].z1, vecs[2].z2, 0, 1'b0);

    // Random operands against the convolution model, random stalls
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      st = int'($urandom_range(0, 3));
      run_check($sformatf("rand%0d", i), ra, rb,
                clmul(ra[31:0], rb[31:0]),
                clmul(ra[31:0] ^ ra[63:32], rb[31:0] ^ rb[63:32]),
                clmul(ra[63:32], rb[63:32]),
                st, (st == 0) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
